register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit general-purpose register file for the processor datapath.
- Sits directly downstream of the 5-bit destination-register mux: consumes the selected 5-bit write address (rt or rd) plus write-back data and write enable.
- Provides two combinational read ports to the ALU operand path.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- RegWrite  input  1  write enable from control unit
- WriteReg  input  ADDR_W  destination register address, from the 5-bit destination mux output
- WriteData  input  DATA_W  write-back data (ALU result or memory load)
- ReadReg1  input  ADDR_W  read address, port 1 (rs)
- ReadReg2  input  ADDR_W  read address, port 2 (rt)
- ReadData1  output  DATA_W  contents of ReadReg1
- ReadData2  output  DATA_W  contents of ReadReg2

Behaviour:
- Storage: array of 2**ADDR_W registers, DATA_W bits each.
- Reset:
  - rst=1 on a rising clk edge clears all entries to 0 in that single cycle.
  - rst has priority over RegWrite in the same cycle; the write is dropped.
  - After reset, ReadData1 and ReadData2 = 0 for every address.
- Write:
  - On a rising clk edge with rst=0, RegWrite=1 and WriteReg!=0, the entry at WriteReg takes WriteData.
  - Write latency: one edge.
  - RegWrite=0: no entry changes.
  - WriteReg=0: write silently ignored; entry 0 stays 0 at all times.
- Read:
  - Fully combinational, zero latency: ReadDataN = entry[ReadRegN].
  - ReadRegN=0 always returns 0.
- Both read ports may address the same register; both return identical data.
- Simultaneous read and write to the same address (without the optional feature):
  - Before the edge, read returns the old value.
  - After the edge, read returns the new value.
- Consecutive writes to the same address: last write wins, one per cycle.
- Reset asserted mid-operation: any write in the reset cycle is lost. Writes resume on the first edge with rst=0.
- Inputs are sampled only at the rising edge. Glitches on WriteReg or WriteData between edges have no effect on state.
- No X propagation: every entry has a defined value after the first reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-through bypass. If RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg in the same cycle, ReadDataN = WriteData combinationally, before the edge.
  - Purpose: a write-back and a decode of the same register in one cycle get the fresh value.
  - Bypass never applies to address 0.
  - Bypass is suppressed while rst=1; reads then show current array contents.
- Not defined:
  - Reads always return stored array contents, per the Read rules above.
  - No bypass mux is synthesized.

Test Plan:
- Reset: preload entries 5 and 31 with 0xDEADBEEF, assert rst one cycle -> ReadData1/2 = 0x00000000 for all 32 addresses; a RegWrite=1 to entry 7 in the same cycle leaves entry 7 = 0.
- Write/read: write 0x12345678 to reg 8 and 0xCAFEF00D to reg 9 on consecutive cycles; ReadReg1=8, ReadReg2=9 -> ReadData1=0x12345678, ReadData2=0xCAFEF00D.
- Register zero: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF -> ReadData1 with ReadReg1=0 stays 0x00000000.
- Write disabled: reg 3 = 0x00000011; RegWrite=0, WriteReg=3, WriteData=0x000000AA -> reg 3 remains 0x00000011.
- Same-cycle read/write: reg 4 = 0x1; drive RegWrite=1, WriteReg=4, WriteData=0x2, ReadReg1=4.
  - Macro undefined: ReadData1=0x1 before the edge, 0x2 after.
  - REGFILE_BYPASS_EN defined: ReadData1=0x2 before the edge.
- Exhaustive sweep: write value (addr*0x01010101) to addresses 1..31, then read all on both ports -> each matches, address 0 = 0; dual-port same-address reads agree.

Source files
------------

// File: rtl/register_file.sv
// 32 x 32-bit register file with two combinational read ports and entry 0 hardwired to zero.
// Optional write-through bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;

    assign wr_en = RegWrite && (WriteReg != '0);

    // Entry 0 is only ever cleared, so it holds zero from the first reset onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[WriteReg] <= WriteData;
        end
    end

    logic [DATA_W-1:0] rd1_arr;
    logic [DATA_W-1:0] rd2_arr;

    assign rd1_arr = (ReadReg1 == '0) ? '0 : mem_q[ReadReg1];
    assign rd2_arr = (ReadReg2 == '0) ? '0 : mem_q[ReadReg2];

`ifdef REGFILE_BYPASS_EN
    logic byp_en;

    // wr_en already excludes address 0, so the bypass never exposes a write to entry 0.
    assign byp_en    = wr_en && !rst;
    assign ReadData1 = (byp_en && (ReadReg1 == WriteReg)) ? WriteData : rd1_arr;
    assign ReadData2 = (byp_en && (ReadReg2 == WriteReg)) ? WriteData : rd2_arr;
`else
    assign ReadData1 = rd1_arr;
    assign ReadData2 = rd2_arr;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations are hand-computed constants.
// Same-cycle read/write expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int vectors;
    int miscompares;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write, applied at the next rising edge; returns #1 after that edge.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = addr;
        WriteData = data;
        @(posedge clk);
        #1;
        RegWrite  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r1;
        logic [31:0] r2;
        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd31, 32'hDEADBEEF);
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd31;
        #1;
        vectors++;
        if (ReadData1 !== 32'hDEADBEEF || ReadData2 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL preload: rd1=%h rd2=%h expected deadbeef", ReadData1, ReadData2);
        end
        @(negedge clk);
        rst       = 1'b1;
        RegWrite  = 1'b1;
        WriteReg  = 5'd7;
        WriteData = 32'h0BADF00D;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadReg1 = 5'(a);
            ReadReg2 = 5'(31 - a);
            #1;
            r1 = ReadData1;
            r2 = ReadData2;
            vectors++;
            if (r1 !== 32'h0 || r2 !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_clear addr=%0d: rd1=%h rd2=%h expected 0", a, r1, r2);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd8, 32'h12345678);
        write_reg(5'd9, 32'hCAFEF00D);
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd9;
        #1;
        vectors++;
        if (ReadData1 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL write_read rd1: got %h expected 12345678", ReadData1);
        end
        vectors++;
        if (ReadData2 !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL write_read rd2: got %h expected cafef00d", ReadData2);
        end
    endtask

    task automatic test_reg_zero();
        write_reg(5'd0, 32'hFFFFFFFF);
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
        #1;
        vectors++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reg_zero: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
        end
    endtask

    task automatic test_write_disabled();
        write_reg(5'd3, 32'h00000011);
        @(negedge clk);
        RegWrite  = 1'b0;
        WriteReg  = 5'd3;
        WriteData = 32'h000000AA;
        @(posedge clk);
        #1;
        ReadReg1 = 5'd3;
        #1;
        vectors++;
        if (ReadData1 !== 32'h00000011) begin
            miscompares++;
            $display("FAIL write_disabled: got %h expected 00000011", ReadData1);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_before;
`ifdef REGFILE_BYPASS_EN
        exp_before = 32'h2;
`else
        exp_before = 32'h1;
`endif
        write_reg(5'd4, 32'h1);
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd4;
        WriteData = 32'h2;
        ReadReg1  = 5'd4;
        ReadReg2  = 5'd4;
        #1;
        vectors++;
        if (ReadData1 !== exp_before || ReadData2 !== exp_before) begin
            miscompares++;
            $display("FAIL same_cycle_before: rd1=%h rd2=%h expected %h",
                     ReadData1, ReadData2, exp_before);
        end
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        #1;
        vectors++;
        if (ReadData1 !== 32'h2) begin
            miscompares++;
            $display("FAIL same_cycle_after: got %h expected 00000002", ReadData1);
        end
    endtask

    task automatic test_back_to_back();
        // Three writes to reg 12 on consecutive edges, with glitches on the inputs between edges.
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd12;
        WriteData = 32'hAAAA0001;
        @(posedge clk);
        #1;
        WriteReg  = 5'd13;
        WriteData = 32'h99999999;
        #2;
        WriteReg  = 5'd12;
        WriteData = 32'hAAAA0002;
        @(posedge clk);
        #1;
        WriteData = 32'hAAAA0003;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        ReadReg1 = 5'd12;
        ReadReg2 = 5'd13;
        #1;
        vectors++;
        if (ReadData1 !== 32'hAAAA0003) begin
            miscompares++;
            $display("FAIL back_to_back last_wins: got %h expected aaaa0003", ReadData1);
        end
        vectors++;
        if (ReadData2 !== 32'h0) begin
            miscompares++;
            $display("FAIL back_to_back glitch: reg13=%h expected 0", ReadData2);
        end
    endtask

    task automatic test_reset_mid();
        write_reg(5'd10, 32'h10101010);
        @(negedge clk);
        rst       = 1'b1;
        RegWrite  = 1'b1;
        WriteReg  = 5'd11;
        WriteData = 32'h11111111;
        ReadReg1  = 5'd10;
        #1;
        // Bypass, if present, must stay off during reset: the stored value shows through.
        vectors++;
        if (ReadData1 !== 32'h10101010) begin
            miscompares++;
            $display("FAIL reset_mid pre_edge: got %h expected 10101010", ReadData1);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        WriteReg  = 5'd14;
        WriteData = 32'h14141414;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        ReadReg1 = 5'd10;
        ReadReg2 = 5'd11;
        #1;
        vectors++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid lost: reg10=%h reg11=%h expected 0", ReadData1, ReadData2);
        end
        ReadReg1 = 5'd14;
        #1;
        vectors++;
        if (ReadData1 !== 32'h14141414) begin
            miscompares++;
            $display("FAIL reset_mid resume: got %h expected 14141414", ReadData1);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        for (int a = 1; a < 32; a++) begin
            write_reg(5'(a), 32'(a) * 32'h01010101);
        end
        for (int a = 0; a < 32; a++) begin
            exp = 32'(a) * 32'h01010101;
            ReadReg1 = 5'(a);
            ReadReg2 = 5'(a);
            #1;
            vectors++;
            if (ReadData1 !== exp || ReadData2 !== exp) begin
                miscompares++;
                $display("FAIL sweep addr=%0d: rd1=%h rd2=%h expected %h",
                         a, ReadData1, ReadData2, exp);
            end
            exp = 32'(31 - a) * 32'h01010101;
            ReadReg2 = 5'(31 - a);
            #1;
            vectors++;
            if (ReadData2 !== exp) begin
                miscompares++;
                $display("FAIL sweep_port2 addr=%0d: got %h expected %h", 31 - a, ReadData2, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        RegWrite    = 1'b0;
        WriteReg    = '0;
        WriteData   = '0;
        ReadReg1    = '0;
        ReadReg2    = '0;
        pulse_reset();

        test_reset();
        test_write_read();
        test_reg_zero();
        test_write_disabled();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
